// File: rtl/serial_sub_pkg.sv
// Purpose: shared types and helpers for the bit-serial subtractor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, cnt_width() counter sizing, ovf_detect() signed overflow rule.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width for a WIDTH-bit operand; clamped to at least one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Signed overflow of a - b: operands of opposite sign and a result whose
  // sign differs from the minuend.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Purpose: one-bit full subtractor cell, borrow-chain dual of the full adder.
// Latency: combinational.
// Backpressure: n/a.
// Ports: x (minuend bit), y (subtrahend bit), bin (borrow in) -> d (difference bit), bout (borrow out).
(* whitebox *)
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  (* carry = "borrow" *)
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x, or when the bits match and a borrow ripples in.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial two's-complement subtractor, diff = a - b - bin, LSB first.
// Latency: out_valid rises WIDTH cycles after the input accept edge.
// Backpressure: result held in DONE until out_ready; in_valid ignored outside IDLE.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, bin;
//        out_valid/out_ready with diff, bout (unsigned borrow), ovf (signed overflow).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  import serial_sub_pkg::*;

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  // Holds the WIDTH-1 most recent difference bits; the final bit comes
  // straight from the cell on the last RUN edge.
  logic [WIDTH-2:0]   res;
  logic               br;
  logic [CNT_W-1:0]   cnt;

  logic               cell_d;
  logic               cell_b;
  logic [WIDTH-1:0]   res_wide;

  full_subtractor u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_b)
  );

  // New bit enters from the MSB side; on the last edge this is the full result.
  assign res_wide  = {cell_d, res};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= cell_b;
          res  <= res_wide[WIDTH-1:1];
          if (cnt == CNT_LAST) begin
            // a_sh[0]/b_sh[0] are the operand MSBs on this final edge.
            diff  <= res_wide;
            bout  <= cell_b;
            ovf   <= ovf_detect(a_sh[0], b_sh[0], cell_d);
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_pass  = 0;
  int n_total = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    logic [W-1:0] e_diff;
    logic         e_bout;
    logic         e_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, borrow as sign of the true result.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo, output logic mov);
    int r;
    logic [31:0] rv;
    r   = int'(ma) - int'(mb) - int'(mbin);
    rv  = r;
    md  = rv[W-1:0];
    mbo = (r < 0);
    mov = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
  endtask

  // Presents operands at a falling edge; returns just after the accept edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    chk("accept_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_in_ready", in_ready, 0);
  endtask

  // Waits for out_valid with a cycle budget; optionally toggles in_valid /
  // out_ready randomly during RUN (both must be ignored there).
  task automatic wait_result(input bit noise);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        a         = W'($urandom);
        b         = W'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("latency", cyc, W);
    chk("done_in_ready", in_ready, 0);
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] ed, input logic eb,
                           input logic eo, input int hold);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"}, ovf, eo);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      chk("hold_stable", {out_valid, in_ready, bout, ovf, diff}, {1'b1, 1'b0, eb, eo, ed});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, {out_valid, in_ready}, 2'b01);
    chk({tag, "_keep"}, {bout, ovf, diff}, {eb, eo, ed});
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] md;
    logic         mbo;
    logic         mov;
    int           cyc;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    chk("reset_state", {in_ready, out_valid, bout, ovf, diff}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vbin);
      wait_result(1'b0);
      finish_op("vec", vecs[i].e_diff, vecs[i].e_bout, vecs[i].e_ovf, 0);
    end

    // Backpressure for 5 cycles, then an immediate second operation.
    start_op(8'hC3, 8'h5A, 1'b1);
    wait_result(1'b0);
    model(8'hC3, 8'h5A, 1'b1, md, mbo, mov);
    finish_op("bp", md, mbo, mov, 5);
    start_op(8'h05, 8'h03, 1'b0);
    wait_result(1'b0);
    finish_op("b2b", 8'h02, 1'b0, 1'b0, 0);

    // Reset after the 3rd RUN edge.
    start_op(8'h33, 8'h11, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_async", {in_ready, out_valid, diff}, {1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    chk("no_stale_result", cyc, 0);
    start_op(8'h05, 8'h03, 1'b0);
    wait_result(1'b0);
    finish_op("post_rst", 8'h02, 1'b0, 1'b0, 0);

    // Randomized operations with noise on ignored handshakes.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, md, mbo, mov);
      start_op(ra, rb, rbin);
      wait_result(1'b1);
      finish_op("rand", md, mbo, mov, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Built around a borrow-chain full-subtractor cell, the logical dual of the carry-chain full adder cell.
- Operands arrive on a valid/ready input channel; the result leaves on a valid/ready output channel.
- Used in the VTR flow tests as a small sequential whitebox consumer of the subtract/borrow primitive.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow out; 1 when the unsigned result is below zero
- ovf  output  1  signed overflow

Behaviour:
- Reset: async on rst_n=0. State=IDLE. in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. Counter, shift registers and borrow register are cleared. Any operation in flight is abandoned with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, combinationally decoded from state.
  - On in_valid & in_ready at an edge: capture a, b into shift registers, bin into the borrow register, clear the bit counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes the current LSB pair (x, y) with borrow br:
    - d = x ^ y ^ br
    - br_next = (~x & y) | (~(x ^ y) & br)
  - d shifts into the result register from the MSB side; the operand registers shift right; counter increments.
  - Before the last bit shifts out, capture the MSBs of a and b for overflow.
  - After the WIDTH-th RUN edge, go to DONE.
  - Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- DONE:
  - out_valid=1.
  - diff, bout=final borrow, and ovf=(a_msb != b_msb) & (diff_msb != a_msb) are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_ready=1 at an edge, go to IDLE. out_valid drops in the next cycle; diff, bout and ovf keep their last values.
- in_ready is 0 in RUN and DONE. in_valid is ignored there, with no buffering. A new accept is possible in the first IDLE cycle, so throughput is one operation per WIDTH+2 cycles at minimum.
- out_ready asserted outside DONE has no effect.
- in_valid and out_ready may both be high in the same cycle: only the handshake legal in the current state takes effect.
- Counter width is $clog2(WIDTH). Terminal count is WIDTH-1, compared explicitly with no reliance on wrap-around.
- No combinational path from in_valid, a, b or bin to any output. Only in_ready and out_valid are state-decoded.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE}
  - constant CNT_W = $clog2(WIDTH) helper
  - function for overflow detection
- Sub-module full_subtractor: combinational whitebox cell, inputs x, y, bin; outputs d, bout; carries the borrow chain attribute. Instantiated once in the datapath.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, bin=0, accepted at edge E0 -> out_valid after E8; diff=0x02, bout=0, ovf=0; in_ready=0 from E0 until the output handshake.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff, bout, ovf and out_valid stable. Then out_ready=1 -> out_valid=0 next cycle and in_ready=1; a second operation issued immediately gives a correct result.
- Reset mid-operation: deassert rst_n after the 3rd RUN edge -> in_ready=1 and out_valid=0 immediately, before any clock edge. After release, no stale result appears, and the next operation 0x05-0x03 gives 0x02.
